// File: rtl/pipe_stage_reg.sv
// Elastic pipeline stage register with optional 2-entry skid buffer,
// bubble-inserting flush and a saturating starvation counter.
module pipe_stage_reg #(
  parameter int DATA_W     = 128,
  parameter int CTRL_W     = 16,
  parameter int SKID       = 1,
  parameter int CLEAR_DATA = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [15:0]       bubble_cnt
);

  logic              mainValid;
  logic [DATA_W-1:0] mainData;
  logic [CTRL_W-1:0] mainCtrl;
  logic              skidValid;
  logic [DATA_W-1:0] skidData;
  logic [CTRL_W-1:0] skidCtrl;
  logic [15:0]       bubbleCnt;
  logic              inXfer;
  logic              loadMain;

  // With a skid entry in_ready comes straight from a flop; without it,
  // the single register may be refilled in the cycle it drains.
  assign in_ready  = (SKID != 0) ? !skidValid
                                 : (!mainValid || out_ready);
  assign inXfer    = in_valid && in_ready;
  assign loadMain  = !mainValid || out_ready;

  assign out_valid  = mainValid;
  assign out_data   = mainData;
  assign out_ctrl   = mainCtrl;
  assign occupancy  = {1'b0, mainValid} + {1'b0, skidValid};
  assign bubble_cnt = bubbleCnt;

  // Beat storage: main drives the outputs, skid absorbs one stalled beat.
  // Control is stored as zero whenever main becomes a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      mainValid <= 1'b0;
      mainData  <= '0;
      mainCtrl  <= '0;
      skidValid <= 1'b0;
      skidData  <= '0;
      skidCtrl  <= '0;
    end else if (flush) begin
      mainValid <= 1'b0;
      mainCtrl  <= '0;
      skidValid <= 1'b0;
      skidCtrl  <= '0;
      if (CLEAR_DATA != 0) begin
        mainData <= '0;
        skidData <= '0;
      end
    end else if (skidValid) begin
      if (out_ready) begin
        mainValid <= 1'b1;
        mainData  <= skidData;
        mainCtrl  <= skidCtrl;
        skidValid <= 1'b0;
        skidCtrl  <= '0;
      end
    end else if (loadMain) begin
      mainValid <= inXfer;
      mainCtrl  <= inXfer ? in_ctrl : '0;
      if (inXfer) begin
        mainData <= in_data;
      end
    end else if (inXfer && (SKID != 0)) begin
      skidValid <= 1'b1;
      skidData  <= in_data;
      skidCtrl  <= in_ctrl;
    end
  end

  // Starvation counter: downstream ready but nothing to give it.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubbleCnt <= '0;
    end else if (!mainValid && out_ready && (bubbleCnt != 16'hFFFF)) begin
      bubbleCnt <= bubbleCnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Randomised and directed check of pipe_stage_reg against a FIFO model.
// Unit 0: SKID=1 CLEAR_DATA=0. Unit 1: SKID=0 CLEAR_DATA=1.
module tb_pipe_stage_reg;

  localparam int DW = 16;
  localparam int CW = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          inValid  [2];
  logic          outReady [2];
  logic          flush    [2];
  logic [DW-1:0] inData   [2];
  logic [CW-1:0] inCtrl   [2];
  logic          inReady  [2];
  logic          outValid [2];
  logic [DW-1:0] outData  [2];
  logic [CW-1:0] outCtrl  [2];
  logic [1:0]    occ      [2];
  logic [15:0]   bub      [2];

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .SKID(1), .CLEAR_DATA(0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(inValid[0]), .in_ready(inReady[0]),
    .in_data(inData[0]), .in_ctrl(inCtrl[0]),
    .flush(flush[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]),
    .out_data(outData[0]), .out_ctrl(outCtrl[0]),
    .occupancy(occ[0]), .bubble_cnt(bub[0])
  );

  pipe_stage_reg #(
    .DATA_W(DW), .CTRL_W(CW), .SKID(0), .CLEAR_DATA(1)
  ) dut1 (
    .clk(clk), .rst(rst),
    .in_valid(inValid[1]), .in_ready(inReady[1]),
    .in_data(inData[1]), .in_ctrl(inCtrl[1]),
    .flush(flush[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]),
    .out_data(outData[1]), .out_ctrl(outCtrl[1]),
    .occupancy(occ[1]), .bubble_cnt(bub[1])
  );

  // Reference model: a FIFO of up to 2 (unit 0) or 1 (unit 1) beats.
  logic [DW-1:0] fd [2][2];
  logic [CW-1:0] fc [2][2];
  int            fn [2];
  logic [DW-1:0] shown [2];
  int            cnt [2];
  logic          rdyExp [2];
  int            nChecks = 0;
  int            nFail = 0;
  bit            quiet = 1'b0;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic modelRdy(input int i);
    if (i == 0) return fn[i] < 2;
    return (fn[i] == 0) || outReady[i];
  endfunction

  task automatic step();
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      rdyExp[i] = modelRdy(i);
      if (!quiet) begin
        check($sformatf("u%0d in_ready", i),
              32'(inReady[i]), 32'(rdyExp[i]));
        check($sformatf("u%0d out_valid", i),
              32'(outValid[i]), 32'(fn[i] > 0));
        check($sformatf("u%0d out_ctrl", i), 32'(outCtrl[i]),
              (fn[i] > 0) ? 32'(fc[i][0]) : 32'd0);
        check($sformatf("u%0d out_data", i),
              32'(outData[i]), 32'(shown[i]));
        check($sformatf("u%0d occupancy", i),
              32'(occ[i]), 32'(fn[i]));
        check($sformatf("u%0d bubble_cnt", i),
              32'(bub[i]), 32'(cnt[i]));
      end
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        fn[i] = 0;
        shown[i] = '0;
        cnt[i] = 0;
      end else begin
        if (fn[i] == 0 && outReady[i] && cnt[i] < 65535) cnt[i]++;
        if (flush[i]) begin
          fn[i] = 0;
          if (i == 1) shown[i] = '0;
        end else begin
          if (fn[i] > 0 && outReady[i]) begin
            fd[i][0] = fd[i][1];
            fc[i][0] = fc[i][1];
            fn[i]--;
          end
          if (inValid[i] && rdyExp[i]) begin
            fd[i][fn[i]] = inData[i];
            fc[i][fn[i]] = inCtrl[i];
            fn[i]++;
          end
          if (fn[i] > 0) shown[i] = fd[i][0];
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d,
                       input logic [CW-1:0] c, input logic r,
                       input logic f);
    for (int i = 0; i < 2; i++) begin
      inValid[i]  = v;
      inData[i]   = d;
      inCtrl[i]   = c;
      outReady[i] = r;
      flush[i]    = f;
    end
  endtask

  initial begin
    int k;
    for (int i = 0; i < 2; i++) begin
      fn[i] = 0;
      shown[i] = '0;
      cnt[i] = 0;
      rdyExp[i] = 1'b1;
    end
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    @(posedge clk);
    #1;
    step();
    rst = 1'b0;
    repeat (5) step();
    check("idle bubble_cnt", 32'(bub[0]), 32'd5);
    check("idle in_ready", 32'(inReady[0]), 32'd1);

    for (int b = 1; b <= 8; b++) begin
      drive(1'b1, 16'(b), 8'hA5, 1'b1, 1'b0);
      step();
    end
    check("stream last", 32'(outData[0]), 32'd8);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) step();

    k = 1;
    for (int c = 0; c < 16; c++) begin
      drive(k <= 4, 16'(k), 8'h3C, (c == 0) || (c >= 4), 1'b0);
      step();
      if (inValid[0] && rdyExp[0]) k++;
      if (c == 2) check("bp occupancy", 32'(occ[0]), 32'd2);
    end

    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) step();
    drive(1'b1, 16'd5, 8'h11, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'd6, 8'h22, 1'b0, 1'b0);
    step();
    check("pre-flush occupancy", 32'(occ[0]), 32'd2);
    drive(1'b1, 16'd7, 8'h33, 1'b0, 1'b1);
    step();
    check("flush out_valid", 32'(outValid[0]), 32'd0);
    check("flush occupancy", 32'(occ[0]), 32'd0);
    check("flush clr data", 32'(outData[1]), 32'd0);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (3) step();

    drive(1'b1, 16'd8, 8'h44, 1'b1, 1'b0);
    step();
    drive(1'b1, 16'd9, 8'h55, 1'b0, 1'b0);
    step();
    drive(1'b1, 16'd9, 8'h55, 1'b1, 1'b0);
    step();
    check("skid0 replace data", 32'(outData[1]), 32'd9);
    check("skid0 replace occ", 32'(occ[1]), 32'd1);
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    repeat (2) step();

    repeat (1500) begin
      for (int i = 0; i < 2; i++) begin
        inValid[i]  = $urandom_range(0, 9) < 7;
        outReady[i] = $urandom_range(0, 9) < 7;
        inData[i]   = 16'($urandom);
        inCtrl[i]   = 8'($urandom);
        flush[i]    = $urandom_range(0, 31) == 0;
      end
      rst = $urandom_range(0, 199) == 0;
      step();
    end

    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();
    rst = 1'b0;
    quiet = 1'b1;
    repeat (65540) step();
    quiet = 1'b0;
    step();
    check("saturated bubble_cnt", 32'(bub[0]), 32'hFFFF);
    rst = 1'b1;
    drive(1'b0, '0, '0, 1'b1, 1'b1);
    step();
    check("rst over flush bubble", 32'(bub[0]), 32'd0);
    rst = 1'b0;
    drive(1'b0, '0, '0, 1'b1, 1'b0);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             nChecks, nFail);
    $finish;
  end

endmodule
